// File: rtl/madv_pkg.sv
// madv_pkg: shared opcode/state types and sizing constants for the madv datapath.
package madv_pkg;
    localparam int MADV_MAX_ELEMS = 128;
    localparam int MADV_DATA_W    = 32;

    typedef enum logic [1:0] {
        MADV_OP_LOAD_IN = 2'd0,
        MADV_OP_LOAD_WT = 2'd1,
        MADV_OP_EXEC    = 2'd2
    } madv_op_e;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_GAP,
        SEQ_EXEC,
        SEQ_RESP
    } madv_seq_state_e;
endpackage

// File: rtl/madv_seq_wdog.sv
// madv_seq_wdog: EXEC watchdog; expired_o is high on the TIMEOUT-th consecutive enabled cycle.
module madv_seq_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt <= '0;
        else       cnt <= en_i ? cnt + 1'b1 : '0;
    end

    assign expired_o = en_i && cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/madv_seq.sv
// madv_seq: command sequencer for the madv int8 dot-product datapath.
// Define MADV_SEQ_TIMEOUT_EN to add the EXEC watchdog (TIMEOUT cycles).
module madv_seq
    import madv_pkg::*;
#(
    parameter int MAX_ELEMS = MADV_MAX_ELEMS,
    parameter int ID_W      = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [2:0]             cmd_count_i,
    input  logic [MADV_DATA_W-1:0] cmd_data_i,
    input  logic [ID_W-1:0]        cmd_id_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [MADV_DATA_W-1:0] rsp_data_o,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic                   rsp_err_o,
    output logic                   dp_data_valid_o,
    output logic [11:0]            dp_data_count_o,
    output logic [MADV_DATA_W-1:0] dp_data_o,
    output logic                   dp_is_input_o,
    output logic                   dp_is_weight_o,
    output logic                   dp_execute_o,
    input  logic                   dp_result_valid_i,
    input  logic [MADV_DATA_W-1:0] dp_result_i
);
    madv_seq_state_e state, state_nxt;

    logic [1:0]             op_q;
    logic [2:0]             cnt_q;
    logic [MADV_DATA_W-1:0] data_q;
    logic [ID_W-1:0]        id_q;
    logic [7:0]             in_fill, wt_fill;
    logic [MADV_DATA_W-1:0] rsp_data_q;
    logic                   rsp_err_q;
    logic                   accept, is_load, load_ok, exec_ok, in_load, exec_done, tmo;
    logic [8:0]             tgt_sum;

    assign accept    = cmd_valid_i && state == SEQ_IDLE;
    assign is_load   = cmd_op_i == MADV_OP_LOAD_IN || cmd_op_i == MADV_OP_LOAD_WT;
    assign tgt_sum   = (cmd_op_i == MADV_OP_LOAD_IN ? {1'b0, in_fill} : {1'b0, wt_fill}) + {6'd0, cmd_count_i};
    assign load_ok   = is_load && cmd_count_i != 3'd0 && cmd_count_i <= 3'd4 && tgt_sum <= 9'(MAX_ELEMS);
    assign exec_ok   = cmd_op_i == MADV_OP_EXEC && in_fill == wt_fill && in_fill != 8'd0;
    assign in_load   = state == SEQ_LOAD;
    assign exec_done = state == SEQ_EXEC && (dp_result_valid_i || tmo);

`ifdef MADV_SEQ_TIMEOUT_EN
    madv_seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (state == SEQ_EXEC),
        .expired_o (tmo)
    );
`else
    logic timeout_unused;
    assign timeout_unused = TIMEOUT > 0;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= SEQ_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEQ_IDLE: if (cmd_valid_i) state_nxt = load_ok ? SEQ_LOAD : exec_ok ? SEQ_EXEC : SEQ_RESP;
            SEQ_LOAD: state_nxt = SEQ_GAP;
            SEQ_GAP:  state_nxt = SEQ_RESP;
            SEQ_EXEC: if (dp_result_valid_i || tmo) state_nxt = SEQ_RESP;
            SEQ_RESP: if (rsp_ready_i) state_nxt = SEQ_IDLE;
            default:  state_nxt = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q       <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            id_q       <= '0;
            in_fill    <= '0;
            wt_fill    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= cmd_op_i;
                cnt_q      <= cmd_count_i;
                data_q     <= cmd_data_i;
                id_q       <= cmd_id_i;
                rsp_data_q <= '0;
                rsp_err_q  <= !(load_ok || exec_ok);
            end
            if (in_load && op_q == MADV_OP_LOAD_IN) in_fill <= in_fill + {5'd0, cnt_q};
            if (in_load && op_q == MADV_OP_LOAD_WT) wt_fill <= wt_fill + {5'd0, cnt_q};
            if (state == SEQ_GAP) rsp_data_q <= {24'd0, op_q == MADV_OP_LOAD_IN ? in_fill : wt_fill};
            // The datapath self-clears its operands on completion, so the fills follow.
            if (exec_done) begin
                in_fill    <= '0;
                wt_fill    <= '0;
                rsp_data_q <= dp_result_valid_i ? dp_result_i : '0;
                rsp_err_q  <= !dp_result_valid_i;
            end
        end
    end

    assign cmd_ready_o     = state == SEQ_IDLE;
    assign rsp_valid_o     = state == SEQ_RESP;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_id_o        = id_q;
    assign rsp_err_o       = rsp_err_q;
    assign dp_data_valid_o = in_load;
    assign dp_data_count_o = in_load ? {9'd0, cnt_q} : '0;
    assign dp_data_o       = in_load ? data_q : '0;
    assign dp_is_input_o   = in_load && op_q == MADV_OP_LOAD_IN;
    assign dp_is_weight_o  = in_load && op_q == MADV_OP_LOAD_WT;
    assign dp_execute_o    = state == SEQ_EXEC;
endmodule

// File: tb/tb_madv_seq.sv
// tb_madv_seq: randomized self-checking bench; the bench plays the datapath and models
// fills and the signed int8 dot product from the commands it issues.
module tb_madv_seq;
    localparam int ID_W = 3;

    logic            clk_i = 1'b0, rst_i = 1'b1;
    logic            cmd_valid_i = 1'b0, cmd_ready_o;
    logic [1:0]      cmd_op_i = '0;
    logic [2:0]      cmd_count_i = '0;
    logic [31:0]     cmd_data_i = '0;
    logic [ID_W-1:0] cmd_id_i = '0;
    logic            rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o;
    logic [31:0]     rsp_data_o;
    logic [ID_W-1:0] rsp_id_o;
    logic            dp_data_valid_o, dp_is_input_o, dp_is_weight_o, dp_execute_o;
    logic [11:0]     dp_data_count_o;
    logic [31:0]     dp_data_o;
    logic            dp_result_valid_i = 1'b0;
    logic [31:0]     dp_result_i = '0;

    always #5 clk_i = ~clk_i;

    madv_seq #(.MAX_ELEMS(128), .ID_W(ID_W), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_count_i(cmd_count_i), .cmd_data_i(cmd_data_i), .cmd_id_i(cmd_id_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
        .dp_data_valid_o(dp_data_valid_o), .dp_data_count_o(dp_data_count_o), .dp_data_o(dp_data_o),
        .dp_is_input_o(dp_is_input_o), .dp_is_weight_o(dp_is_weight_o), .dp_execute_o(dp_execute_o),
        .dp_result_valid_i(dp_result_valid_i), .dp_result_i(dp_result_i)
    );

    int n_chk = 0, n_fail = 0;
    int in_fill = 0, wt_fill = 0;
    logic [7:0] in_b [128];
    logic [7:0] wt_b [128];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] dot();
        int s = 0;
        for (int i = 0; i < in_fill; i++) s += int'($signed(in_b[i])) * int'($signed(wt_b[i]));
        return 32'(s);
    endfunction

    task automatic do_reset;
        rst_i = 1'b1;
        tick;
        tick;
        rst_i = 1'b0;
        in_fill = 0;
        wt_fill = 0;
    endtask

    task automatic finish_rsp(input int bp, input logic [31:0] d, input logic [ID_W-1:0] id, input logic err);
        for (int k = 0; k < bp; k++) begin
            cmd_valid_i = 1'b1;
            cmd_op_i    = 2'd3;
            check("bp_valid", 32'(rsp_valid_o), 1);
            check("bp_data", rsp_data_o, d);
            check("bp_id", 32'(rsp_id_o), 32'(id));
            check("bp_ready", 32'(cmd_ready_o), 0);
            tick;
        end
        check("rsp_valid", 32'(rsp_valid_o), 1);
        check("rsp_data", rsp_data_o, d);
        check("rsp_id", 32'(rsp_id_o), 32'(id));
        check("rsp_err", 32'(rsp_err_o), 32'(err));
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b0;
        check("rsp_done", 32'(rsp_valid_o), 0);
        check("ready_after", 32'(cmd_ready_o), 1);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [31:0] data,
                          input logic [ID_W-1:0] id, input int lat, input int bp);
        bit ld_ok, ex_ok;
        int f;
        logic [31:0] res;
        f     = (op == 2'd0) ? in_fill : wt_fill;
        ld_ok = op < 2'd2 && cnt >= 3'd1 && cnt <= 3'd4 && f + int'(cnt) <= 128;
        ex_ok = op == 2'd2 && in_fill == wt_fill && in_fill != 0;
        check("cmd_ready", 32'(cmd_ready_o), 1);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_count_i = cnt;
        cmd_data_i  = data;
        cmd_id_i    = id;
        tick;
        cmd_valid_i = 1'b0;
        cmd_data_i  = $urandom;
        cmd_id_i    = ~id;
        check("busy", 32'(cmd_ready_o), 0);
        if (ld_ok) begin
            dp_result_valid_i = 1'b1;
            check("ld_dv", 32'(dp_data_valid_o), 1);
            check("ld_is_in", 32'(dp_is_input_o), 32'(op == 2'd0));
            check("ld_is_wt", 32'(dp_is_weight_o), 32'(op == 2'd1));
            check("ld_count", 32'(dp_data_count_o), 32'(cnt));
            check("ld_data", dp_data_o, data);
            check("ld_rsp", 32'(rsp_valid_o), 0);
            for (int i = 0; i < int'(cnt); i++) begin
                if (op == 2'd0) in_b[in_fill + i] = data[8*i +: 8];
                else            wt_b[wt_fill + i] = data[8*i +: 8];
            end
            if (op == 2'd0) in_fill += int'(cnt);
            else            wt_fill += int'(cnt);
            tick;
            dp_result_valid_i = 1'b0;
            check("gap_dv", 32'(dp_data_valid_o), 0);
            check("gap_rsp", 32'(rsp_valid_o), 0);
            tick;
            finish_rsp(bp, 32'(op == 2'd0 ? in_fill : wt_fill), id, 1'b0);
        end else if (ex_ok) begin
            res = dot();
            for (int k = 0; k < lat; k++) begin
                check("exec_hold", 32'(dp_execute_o), 1);
                check("exec_rsp", 32'(rsp_valid_o), 0);
                tick;
            end
            check("exec_last", 32'(dp_execute_o), 1);
            dp_result_valid_i = 1'b1;
            dp_result_i       = res;
            tick;
            dp_result_valid_i = 1'b0;
            dp_result_i       = $urandom;
            check("exec_drop", 32'(dp_execute_o), 0);
            in_fill = 0;
            wt_fill = 0;
            finish_rsp(bp, res, id, 1'b0);
        end else begin
            check("rej_dv", 32'(dp_data_valid_o), 0);
            check("rej_exec", 32'(dp_execute_o), 0);
            finish_rsp(bp, 32'd0, id, 1'b1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, n;
        logic [2:0] c;
        tick;
        tick;
        rst_i = 1'b0;
        check("rst_ready", 32'(cmd_ready_o), 1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 0);
        check("rst_rsp_data", rsp_data_o, 0);
        check("rst_rsp_id", 32'(rsp_id_o), 0);
        check("rst_rsp_err", 32'(rsp_err_o), 0);
        check("rst_dv", 32'(dp_data_valid_o), 0);
        check("rst_count", 32'(dp_data_count_o), 0);
        check("rst_data", dp_data_o, 0);
        check("rst_flags", {30'd0, dp_is_input_o, dp_is_weight_o}, 0);
        check("rst_exec", 32'(dp_execute_o), 0);
        for (int k = 0; k < 3; k++) begin
            dp_result_valid_i = 1'b1;
            tick;
            check("idle_stray", 32'(rsp_valid_o), 0);
        end
        dp_result_valid_i = 1'b0;

        do_cmd(2'd0, 3'd4, 32'h0403_0201, 3'd5, 0, 0);
        for (int i = 1; i < 32; i++) do_cmd(2'd0, 3'd4, $urandom, 3'(i), 0, 0);
        for (int i = 0; i < 32; i++) do_cmd(2'd1, 3'd4, $urandom, 3'(i), 0, $urandom_range(0, 2));
        do_cmd(2'd2, 3'd0, 32'd0, 3'd3, 4, 0);
        do_cmd(2'd1, 3'd4, $urandom, 3'd1, 0, 0);

        do_reset;
        for (int i = 0; i < 31; i++) do_cmd(2'd0, 3'd4, $urandom, 3'(i), 0, 0);
        do_cmd(2'd0, 3'd3, $urandom, 3'd2, 0, 0);
        do_cmd(2'd0, 3'd2, $urandom, 3'd6, 0, 0);
        do_cmd(2'd3, 3'd4, $urandom, 3'd7, 0, 0);
        do_cmd(2'd2, 3'd0, 32'd0, 3'd4, 0, 0);

        do_reset;
        do_cmd(2'd0, 3'd4, $urandom, 3'd1, 0, 0);
        do_cmd(2'd0, 3'd4, $urandom, 3'd2, 0, 0);
        do_cmd(2'd1, 3'd4, $urandom, 3'd3, 0, 0);
        do_cmd(2'd2, 3'd0, 32'd0, 3'd4, 0, 0);
        do_cmd(2'd0, 3'd0, $urandom, 3'd5, 0, 0);
        do_cmd(2'd1, 3'd5, $urandom, 3'd6, 0, 0);
        do_cmd(2'd1, 3'd4, $urandom, 3'd7, 0, 0);
        do_cmd(2'd2, 3'd0, 32'd0, 3'd2, 3, 10);

        do_cmd(2'd0, 3'd4, $urandom, 3'd1, 0, 0);
        do_cmd(2'd1, 3'd4, $urandom, 3'd2, 0, 0);
        cmd_valid_i = 1'b1;
        cmd_op_i    = 2'd2;
        cmd_id_i    = 3'd6;
        tick;
        cmd_valid_i = 1'b0;
        tick;
        check("mid_exec", 32'(dp_execute_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_exec_drop", 32'(dp_execute_o), 0);
        check("rst_exec_rsp", 32'(rsp_valid_o), 0);
        check("rst_exec_ready", 32'(cmd_ready_o), 1);
        tick;
        rst_i = 1'b0;
        in_fill = 0;
        wt_fill = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("rst_no_rsp", 32'(rsp_valid_o), 0);
        end
        do_cmd(2'd0, 3'd4, $urandom, 3'd0, 0, 0);
        do_cmd(2'd1, 3'd4, $urandom, 3'd1, 0, 0);

`ifdef MADV_SEQ_TIMEOUT_EN
        cmd_valid_i = 1'b1;
        cmd_op_i    = 2'd2;
        cmd_id_i    = 3'd3;
        tick;
        cmd_valid_i = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && dp_execute_o; k++) begin
            n++;
            tick;
        end
        check("tmo_cycles", 32'(n), 16);
        in_fill = 0;
        wt_fill = 0;
        finish_rsp(0, 32'd0, 3'd3, 1'b1);
        do_cmd(2'd2, 3'd0, 32'd0, 3'd4, 0, 0);
`endif

        for (int it = 0; it < 50; it++) begin
            r = $urandom_range(0, 9);
            c = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
            if (r < 7) begin
                do_cmd(2'd0, c, $urandom, 3'($urandom), 0, $urandom_range(0, 3));
                do_cmd(2'd1, c, $urandom, 3'($urandom), 0, $urandom_range(0, 3));
            end else if (r < 9) begin
                do_cmd(2'd2, 3'd0, $urandom, 3'($urandom), $urandom_range(0, 5), $urandom_range(0, 3));
            end else begin
                do_cmd(2'($urandom_range(0, 3)), c, $urandom, 3'($urandom), 0, $urandom_range(0, 3));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/madv_seq.md
# madv_seq

Command sequencer for the `madv` 128-lane int8 dot-product datapath. It sits between the CVXIF coprocessor decode stage and the datapath. It accepts one command at a time (load input bytes, load weight bytes, execute) and turns each command into the datapath's pulse/hold protocol. It tracks operand fill levels, rejects illegal or overflowing commands, and returns exactly one tagged response per command.

## Interface
Parameters:
- `MAX_ELEMS`, 128: operand capacity per bus, in bytes.
- `ID_W`, 3: width of the command/response tag.
- `TIMEOUT`, 64: watchdog limit for EXEC, in cycles. Used only with the macro in Configuration.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is asynchronous and active-high.
- `cmd_valid_i` in 1: command offered.
- `cmd_ready_o` out 1: sequencer can accept a command.
- `cmd_op_i` in 2: opcode. 0 = LOAD_IN, 1 = LOAD_WT, 2 = EXEC, 3 = illegal.
- `cmd_count_i` in 3: number of valid bytes in `cmd_data_i` for loads, 1..4.
- `cmd_data_i` in 32: packed bytes, lane 0 in [7:0].
- `cmd_id_i` in ID_W: tag echoed on the response.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed.
- `rsp_data_o` out 32: load response = updated fill level of the targeted bus; EXEC response = signed dot product.
- `rsp_id_o` out ID_W: tag of the command being answered.
- `rsp_err_o` out 1: command rejected or aborted.
- `dp_data_valid_o` out 1: load strobe to the datapath.
- `dp_data_count_o` out 12: byte count for the load.
- `dp_data_o` out 32: load payload.
- `dp_is_input_o` out 1: load targets the input bus.
- `dp_is_weight_o` out 1: load targets the weight bus.
- `dp_execute_o` out 1: execute request, held while active.
- `dp_result_valid_i` in 1: result strobe from the datapath.
- `dp_result_i` in 32: datapath result.

## Operation
- States: IDLE, LOAD, GAP, EXEC, RESP.
- IDLE: `cmd_ready_o` is 1. On `cmd_valid_i & cmd_ready_o` the command is latched (op, count, data, id).
  - LOAD_IN / LOAD_WT with count in 1..4 and fill+count <= MAX_ELEMS: go to LOAD.
  - EXEC with in_fill == wt_fill and in_fill != 0: go to EXEC.
  - Anything else (op 3, count 0 or >4, overflow, fill mismatch, both fills zero): go to RESP with err=1, data=0. No datapath activity occurs.
- LOAD: lasts 1 cycle.
  - `dp_data_valid_o`=1 and the matching `dp_is_*_o`=1. `dp_data_count_o` = count zero-extended, `dp_data_o` = payload.
  - The targeted fill counter increments by count.
  - Next state is GAP.
- GAP: 1 cycle with all dp strobes low. This is mandatory because the datapath edge-detects `data_valid`. Next state is RESP, err=0, data = new fill.
- EXEC: `dp_execute_o`=1 every cycle until `dp_result_valid_i` is sampled high.
  - On that cycle the sequencer captures `dp_result_i`, drops execute and clears both fill counters; the datapath self-clears its operand buffers after producing a result.
  - Next state is RESP, err=0.
- `dp_result_valid_i` outside EXEC is ignored; the datapath also echoes it on loads.
- RESP: `rsp_valid_o`=1, with data/id/err stable until `rsp_ready_i`. On the handshake cycle go to IDLE.
- Fill counters are 8 bits and saturate logically at MAX_ELEMS because the overflow check prevents wrap.

## Timing
- Reset values: every output is 0 except `cmd_ready_o`=1 (IDLE). Fill counters are 0 and the state is IDLE. Reset mid-command discards the command and produces no response.
- Load: accept at cycle 0, `dp_data_valid_o` at cycle 1, GAP at cycle 2, `rsp_valid_o` from cycle 3.
- EXEC: `dp_execute_o` from cycle 1 through the cycle `dp_result_valid_i` is seen (inclusive). `rsp_valid_o` is asserted the following cycle.
- Rejected command: `rsp_valid_o` at cycle 1.
- `cmd_ready_o` is 0 from the cycle after accept until the cycle after the response handshake.
- The earliest next accept is 1 cycle after the handshake; there is no combinational ready→valid path.
- If `rsp_ready_i` is already 1 when RESP is entered, the response lasts exactly 1 cycle.

## Configuration
- Macro: `MADV_SEQ_TIMEOUT_EN`.
- With the macro defined:
  - A cycle counter runs in EXEC.
  - If TIMEOUT cycles elapse without `dp_result_valid_i`, execute drops, the fill counters clear, and RESP is entered with err=1, data=0.
  - A result arriving in the same cycle as the timeout wins: err=0.
- Without the macro: EXEC waits indefinitely, the counter is absent and TIMEOUT is unused.

## Structure
- Shared package `madv_pkg`:
  - opcode enum (`MADV_OP_LOAD_IN`, `MADV_OP_LOAD_WT`, `MADV_OP_EXEC`)
  - sequencer state enum
  - `MADV_MAX_ELEMS` = 128
  - `MADV_DATA_W` = 32
- One sub-module is natural: `madv_seq_wdog`, the EXEC timeout counter. It is instantiated only under `MADV_SEQ_TIMEOUT_EN`.
- Everything else stays flat in `madv_seq`.

## Test plan
- Reset then idle: all outputs 0 and `cmd_ready_o`=1; `dp_result_valid_i` pulses produce no response.
- LOAD_IN count 4, data 0x04030201, id 5:
  - one-cycle `dp_data_valid_o` with `dp_is_input_o`=1 and `dp_data_count_o`=4, then one gap cycle;
  - response data=4, id=5, err=0.
- 32× LOAD_IN and 32× LOAD_WT of 4 bytes, then EXEC with a model result of 0x0000_1234:
  - execute held until the result strobe;
  - response data=0x1234, err=0;
  - the next LOAD response reports fill 4 (counters were cleared by EXEC).
- Overflow: with in_fill 127, LOAD_IN count 2 gives err=1, data=0 and no `dp_data_valid_o`. Opcode 3 and EXEC with fills 8/4 also give err=1.
- Backpressure: hold `rsp_ready_i`=0 for 10 cycles; the response stays stable, `cmd_ready_o` stays 0, and the offered command is not accepted until 1 cycle after the handshake.
- With `MADV_SEQ_TIMEOUT_EN` and TIMEOUT=16, EXEC with no result strobe gives err=1 after 16 cycles and both fills 0. Reset asserted mid-EXEC drops execute immediately and produces no response.
